ir_sensor_array: RTL and testbench
==================================

IR_SENSOR_ARRAY -- requirements
Module: ir_sensor_array

Interface
REQ-001 The block SHALL have the following parameters:
- N_CH, default 5, number of infrared sensor channels (1..32).
- FILT_CYCLES, default 1000, stable cycles required before an output changes (1..65535).
- INVERT, default 0, when 1 each filtered output is the logical inverse of its sensor level.

REQ-002 The block SHALL have the following ports (clock and reset first):
- clk  input  1  system clock; the block uses one clock.
- rst  input  1  reset; asynchronous, active-high.
- ising  input  N_CH  raw sensor levels, asynchronous to clk.
- osing  output  N_CH  filtered, synchronised sensor levels.
- rise  output  N_CH  sticky flag per channel: filtered level went 0->1.
- fall  output  N_CH  sticky flag per channel: filtered level went 1->0.
- clr_rise  input  N_CH  one-cycle, write-one-to-clear pulse per rise bit.
- clr_fall  input  N_CH  one-cycle, write-one-to-clear pulse per fall bit.
- irq_mask  input  N_CH  interrupt enable per channel.
- irq  output  1  interrupt request.

Function
REQ-003 Each ising bit SHALL pass through a 2-flop synchroniser; sync[i] is the second flop output.
REQ-004 When INVERT=1, the synchroniser output SHALL be inverted before filtering; when INVERT=0 it SHALL pass uncorrected.
REQ-005 Each channel SHALL have an independent counter, ceil(log2(FILT_CYCLES+1)) bits wide, that never wraps.
REQ-006 In any cycle where sync[i] equals osing[i], the channel counter SHALL load 0.
REQ-007 In any cycle where sync[i] differs from osing[i]:
- If the count is below FILT_CYCLES-1, the counter SHALL increment.
- If the count equals FILT_CYCLES-1, osing[i] SHALL toggle on that clock edge and the counter SHALL load 0.
REQ-008 A glitch shorter than FILT_CYCLES cycles at sync[i] SHALL leave osing[i] unchanged, and the counter SHALL restart from 0 once the glitch ends.
REQ-009 Latency from a stable ising change to the osing change SHALL be exactly 2+FILT_CYCLES clk edges.
- With FILT_CYCLES=1, osing SHALL follow sync with one cycle of delay.
REQ-010 On the edge where osing[i] toggles 0->1, rise[i] SHALL set; on a 1->0 toggle, fall[i] SHALL set.
REQ-011 A clr_rise[i] or clr_fall[i] pulse SHALL clear the corresponding flag on the next edge.
REQ-012 If a set and a clear of the same flag coincide in one cycle, the set SHALL win.
REQ-013 Flags of different channels, and the rise and fall flags of one channel, SHALL be independent.
REQ-014 irq SHALL be registered: irq = OR over i of ((rise[i] | fall[i]) & irq_mask[i]), valid one cycle after the flags.
REQ-015 Changing irq_mask SHALL take effect on irq one cycle later and SHALL NOT modify any flag.
REQ-016 The channels SHALL be generated from N_CH with no per-channel hand-written logic; N_CH=1 SHALL be legal.

Reset
REQ-017 When rst is asserted, the following SHALL take their reset values immediately, without waiting for clk:
- Synchroniser flops: INVERT value (so the post-inversion level is 0).
- osing: 0.
- Counters: 0.
- rise, fall: 0.
- irq: 0.
REQ-018 After rst deasserts, a sensor already at the active level SHALL produce a normal 0->1 transition 2+FILT_CYCLES cycles later and set rise.
REQ-019 If rst asserts mid-filtering, all in-progress counts SHALL be discarded and no flag SHALL be set by that partial count.

Verification
REQ-020 The bench SHALL cover these directed scenarios (N_CH=5, FILT_CYCLES=4, INVERT=0 unless stated):
- Latency: ising[0] 0->1 held → osing[0]=1 exactly 6 edges later; rise[0]=1 on that edge; irq=1 one cycle after, with irq_mask=5'b00001.
- Glitch: ising[2] high for 3 cycles, then low → osing[2] stays 0, rise[2] stays 0, counter returns to 0.
- Clear race: clr_rise[0] pulsed in the same cycle a new 0->1 toggle sets rise[0] → rise[0]=1. A clr_rise[0] pulse alone → rise[0]=0 next cycle, irq=0 one cycle later.
- Masking: fall[3] set with irq_mask=0 → irq=0; set irq_mask[3]=1 → irq=1 next cycle; fall[3] still 1.
- Inversion: INVERT=1, ising=5'b11111 at reset release → osing stays 5'b00000 and no flags set; ising[1] 1->0 → osing[1]=1 after 6 edges, rise[1]=1.
- Reset mid-filter: ising[4] high for 2 cycles, assert rst asynchronously, then release with ising[4] high → all outputs 0 during reset; osing[4]=1 six edges after release.

Source files
------------

// File: rtl/ir_sensor_array_if.sv
// Sensor-array bus: raw levels in, filtered levels, sticky edge flags and interrupt out.
interface ir_sensor_array_if #(
    parameter int N_CH = 5
);
    logic [N_CH-1:0] ising;
    logic [N_CH-1:0] osing;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] clr_rise;
    logic [N_CH-1:0] clr_fall;
    logic [N_CH-1:0] irq_mask;
    logic            irq;

    modport master (
        output ising, clr_rise, clr_fall, irq_mask,
        input  osing, rise, fall, irq
    );

    modport slave (
        input  ising, clr_rise, clr_fall, irq_mask,
        output osing, rise, fall, irq
    );
endinterface

// File: rtl/ir_sensor_array.sv
// Infrared sensor array: per-channel synchroniser, stability filter,
// sticky rise/fall flags with write-one-to-clear, and a masked interrupt.
module ir_sensor_array #(
    parameter int N_CH        = 5,
    parameter int FILT_CYCLES = 1000,
    parameter int INVERT      = 0
) (
    input  logic             clk,
    input  logic             rst,
    ir_sensor_array_if.slave bus
);
    localparam int              CNT_W    = $clog2(FILT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);
    // Synchroniser reset value doubles as the inversion mask, so the
    // post-inversion level is 0 while in reset.
    localparam logic [N_CH-1:0] INV_MASK = (INVERT != 0) ? '1 : '0;

    logic [N_CH-1:0] meta_q, meta_d;
    logic [N_CH-1:0] sync_q, sync_d;
    logic [N_CH-1:0] osing_q, osing_d;
    logic [N_CH-1:0] rise_q, rise_d;
    logic [N_CH-1:0] fall_q, fall_d;
    logic            irq_q, irq_d;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] toggle;

    assign level = sync_q ^ INV_MASK;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             differ;

        assign differ    = level[i] ^ osing_q[i];
        assign toggle[i] = differ && (cnt_q == CNT_LAST);

        always_comb begin
            // NOTE: default first, so no path leaves cnt_d unassigned (no latch).
            cnt_d = '0;
            if (differ && (cnt_q != CNT_LAST)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    always_comb begin
        meta_d  = bus.ising;
        sync_d  = meta_q;
        osing_d = osing_q ^ toggle;
        // A set on the toggle edge overrides a coincident clear.
        rise_d  = (rise_q & ~bus.clr_rise) | (toggle & ~osing_q);
        fall_d  = (fall_q & ~bus.clr_fall) | (toggle & osing_q);
        irq_d   = |((rise_q | fall_q) & bus.irq_mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= INV_MASK;
            sync_q  <= INV_MASK;
            osing_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            osing_q <= osing_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            irq_q   <= irq_d;
        end
    end

    assign bus.osing = osing_q;
    assign bus.rise  = rise_q;
    assign bus.fall  = fall_q;
    assign bus.irq   = irq_q;
endmodule

// File: tb/tb_ir_sensor_array.sv
// Directed bench for ir_sensor_array: table-driven vectors on a non-inverting
// instance plus hand sequences for inversion and reset mid-filter.
module tb_ir_sensor_array;
    localparam int N = 5;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ir_sensor_array_if #(.N_CH(N)) bus0 ();
    ir_sensor_array_if #(.N_CH(N)) bus1 ();

    ir_sensor_array #(.N_CH(N), .FILT_CYCLES(4), .INVERT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    ir_sensor_array #(.N_CH(N), .FILT_CYCLES(4), .INVERT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] ising;
        logic [N-1:0] clr_rise;
        logic [N-1:0] clr_fall;
        logic [N-1:0] mask;
        int           cyc;
        logic [N-1:0] exp_osing;
        logic [N-1:0] exp_rise;
        logic [N-1:0] exp_fall;
        logic         exp_irq;
    } vec_t;

    vec_t vec [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic edge_wait(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        // ising, clr_rise, clr_fall, mask, cyc -> osing, rise, fall, irq
        vec[0]  = '{5'b00001, 5'b00000, 5'b00000, 5'b00001, 5, 5'b00000, 5'b00000, 5'b00000, 1'b0};
        vec[1]  = '{5'b00001, 5'b00000, 5'b00000, 5'b00001, 1, 5'b00001, 5'b00001, 5'b00000, 1'b0};
        vec[2]  = '{5'b00001, 5'b00000, 5'b00000, 5'b00001, 1, 5'b00001, 5'b00001, 5'b00000, 1'b1};
        // 3-cycle glitch on channel 2 is absorbed
        vec[3]  = '{5'b00101, 5'b00000, 5'b00000, 5'b00001, 3, 5'b00001, 5'b00001, 5'b00000, 1'b1};
        vec[4]  = '{5'b00001, 5'b00000, 5'b00000, 5'b00001, 5, 5'b00001, 5'b00001, 5'b00000, 1'b1};
        // channel 2 needs a full filter period again; channel 0 falls
        vec[5]  = '{5'b00100, 5'b00000, 5'b00000, 5'b00001, 5, 5'b00001, 5'b00001, 5'b00000, 1'b1};
        vec[6]  = '{5'b00100, 5'b00000, 5'b00000, 5'b00001, 1, 5'b00100, 5'b00101, 5'b00001, 1'b1};
        // clear of rise[0] coincides with a new rise toggle: set wins
        vec[7]  = '{5'b00101, 5'b00000, 5'b00000, 5'b00001, 5, 5'b00100, 5'b00101, 5'b00001, 1'b1};
        vec[8]  = '{5'b00101, 5'b00001, 5'b00000, 5'b00001, 1, 5'b00101, 5'b00101, 5'b00001, 1'b1};
        vec[9]  = '{5'b00101, 5'b00001, 5'b00001, 5'b00001, 1, 5'b00101, 5'b00100, 5'b00000, 1'b1};
        vec[10] = '{5'b00101, 5'b00000, 5'b00000, 5'b00001, 1, 5'b00101, 5'b00100, 5'b00000, 1'b0};
        // channel 3 up then down with irq masked
        vec[11] = '{5'b01101, 5'b00000, 5'b00000, 5'b00000, 6, 5'b01101, 5'b01100, 5'b00000, 1'b0};
        vec[12] = '{5'b00101, 5'b00000, 5'b00000, 5'b00000, 6, 5'b00101, 5'b01100, 5'b01000, 1'b0};
        vec[13] = '{5'b00101, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00101, 5'b01100, 5'b01000, 1'b0};
        vec[14] = '{5'b00101, 5'b00000, 5'b00000, 5'b01000, 1, 5'b00101, 5'b01100, 5'b01000, 1'b1};
        vec[15] = '{5'b00101, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00101, 5'b01100, 5'b01000, 1'b0};

        rst           = 1'b1;
        bus0.ising    = '0;
        bus0.clr_rise = '0;
        bus0.clr_fall = '0;
        bus0.irq_mask = '0;
        bus1.ising    = '1;
        bus1.clr_rise = '0;
        bus1.clr_fall = '0;
        bus1.irq_mask = '0;

        // Reset values before any clock edge
        #2;
        check("rst osing0", 32'(bus0.osing), 32'h0);
        check("rst rise0", 32'(bus0.rise), 32'h0);
        check("rst fall0", 32'(bus0.fall), 32'h0);
        check("rst irq0", 32'(bus0.irq), 32'h0);
        check("rst osing1", 32'(bus1.osing), 32'h0);

        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 16; k++) begin
            bus0.ising    = vec[k].ising;
            bus0.irq_mask = vec[k].mask;
            bus0.clr_rise = vec[k].clr_rise;
            bus0.clr_fall = vec[k].clr_fall;
            for (int c = 0; c < vec[k].cyc; c++) begin
                @(posedge clk);
                #1;
                bus0.clr_rise = '0;
                bus0.clr_fall = '0;
            end
            check($sformatf("v%0d osing", k), 32'(bus0.osing), 32'(vec[k].exp_osing));
            check($sformatf("v%0d rise", k), 32'(bus0.rise), 32'(vec[k].exp_rise));
            check($sformatf("v%0d fall", k), 32'(bus0.fall), 32'(vec[k].exp_fall));
            check($sformatf("v%0d irq", k), 32'(bus0.irq), 32'(vec[k].exp_irq));
        end

        // Inverted instance: all sensors at 1 since reset means inactive
        check("inv idle osing", 32'(bus1.osing), 32'h0);
        check("inv idle rise", 32'(bus1.rise), 32'h0);
        check("inv idle fall", 32'(bus1.fall), 32'h0);
        bus1.ising    = 5'b11101;
        bus1.irq_mask = 5'b00010;
        edge_wait(5);
        check("inv osing @5", 32'(bus1.osing), 32'h0);
        check("inv rise @5", 32'(bus1.rise), 32'h0);
        edge_wait(1);
        check("inv osing @6", 32'(bus1.osing), 32'h02);
        check("inv rise @6", 32'(bus1.rise), 32'h02);
        check("inv fall @6", 32'(bus1.fall), 32'h0);
        edge_wait(1);
        check("inv irq @7", 32'(bus1.irq), 32'h1);

        // Reset asserted mid-filter, away from any clock edge
        bus0.ising    = 5'b10000;
        bus0.irq_mask = 5'b11111;
        edge_wait(2);
        #3;
        rst = 1'b1;
        #1;
        check("mid rst osing0", 32'(bus0.osing), 32'h0);
        check("mid rst rise0", 32'(bus0.rise), 32'h0);
        check("mid rst fall0", 32'(bus0.fall), 32'h0);
        check("mid rst irq0", 32'(bus0.irq), 32'h0);
        check("mid rst osing1", 32'(bus1.osing), 32'h0);
        check("mid rst rise1", 32'(bus1.rise), 32'h0);
        check("mid rst irq1", 32'(bus1.irq), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        edge_wait(5);
        check("post rst osing0 @5", 32'(bus0.osing), 32'h0);
        check("post rst rise0 @5", 32'(bus0.rise), 32'h0);
        edge_wait(1);
        check("post rst osing0 @6", 32'(bus0.osing), 32'h10);
        check("post rst rise0 @6", 32'(bus0.rise), 32'h10);
        check("post rst fall0 @6", 32'(bus0.fall), 32'h0);
        edge_wait(1);
        check("post rst irq0 @7", 32'(bus0.irq), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
